// File: rtl/fp_vec_addsub_seq.sv
// Vector sequencer for the combinational FP32 add/sub ALU: one element pair per clock, results gathered into a vector.
// Optional build macro FP_VEC_ABORT_ON_EXC_EN: end the operation early on the first ALU exception.
module fp_vec_addsub_seq #(
    parameter int LANES = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic                  sub_i,
    input  logic [32*LANES-1:0]   vec_a_i,
    input  logic [32*LANES-1:0]   vec_b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [32*LANES-1:0]   vec_res_o,
    output logic [LANES-1:0]      exc_mask_o,
    output logic                  abort_o,
    output logic [31:0]           alu_a_o,
    output logic [31:0]           alu_b_o,
    output logic                  alu_sub_o,
    input  logic [31:0]           alu_result_i,
    input  logic                  alu_exc_i
);

    localparam int CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    // Handshake: start_i is a level sampled only in IDLE; done_o is a single-cycle
    // pulse, and busy_o covers RUN and DONE so a new start is taken the cycle after done_o.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idx, idx_nxt;
    logic             launch;
    logic             retire;
`ifdef FP_VEC_ABORT_ON_EXC_EN
    logic             abort_hit;
    logic             abort_q;
`endif

    logic [31:0]      a_mem   [LANES];
    logic [31:0]      b_mem   [LANES];
    logic [31:0]      res_mem [LANES];
    logic             sub_q;
    logic [LANES-1:0] exc_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        launch    = 1'b0;
        retire    = 1'b0;
`ifdef FP_VEC_ABORT_ON_EXC_EN
        abort_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    launch    = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                retire = 1'b1;
                if (idx == LAST) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
`ifdef FP_VEC_ABORT_ON_EXC_EN
                // The faulting element is still stored; everything after it stays cleared.
                if (alu_exc_i) begin
                    abort_hit = 1'b1;
                    idx_nxt   = idx;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < LANES; k++) begin
                a_mem[k]   <= '0;
                b_mem[k]   <= '0;
                res_mem[k] <= '0;
            end
            sub_q <= 1'b0;
            exc_q <= '0;
        end else if (launch) begin
            for (int k = 0; k < LANES; k++) begin
                a_mem[k]   <= vec_a_i[32*k +: 32];
                b_mem[k]   <= vec_b_i[32*k +: 32];
                res_mem[k] <= '0;
            end
            sub_q <= sub_i;
            exc_q <= '0;
        end else if (retire) begin
            res_mem[idx] <= alu_result_i;
            exc_q[idx]   <= alu_exc_i;
        end
    end

`ifdef FP_VEC_ABORT_ON_EXC_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            abort_q <= 1'b0;
        end else if (launch) begin
            abort_q <= 1'b0;
        end else if (abort_hit) begin
            abort_q <= 1'b1;
        end
    end

    assign abort_o = abort_q;
`else
    assign abort_o = 1'b0;
`endif

    assign busy_o     = (state == RUN) || (state == DONE);
    assign done_o     = (state == DONE);
    assign exc_mask_o = exc_q;

    // Operands are decoded from the registered index so the ALU sees stable inputs all cycle.
    assign alu_a_o   = (state == RUN) ? a_mem[idx] : 32'h0;
    assign alu_b_o   = (state == RUN) ? b_mem[idx] : 32'h0;
    assign alu_sub_o = (state == RUN) ? sub_q : 1'b0;

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign vec_res_o[32*g +: 32] = res_mem[g];
    end

endmodule
